// File: rtl/ppu_fb_arbiter_pkg.sv
// Shared types and constants for the PPU framebuffer arbiter.
package ppu_fb_pkg;

    localparam int FB_W_C = 256;
    localparam int FB_H_C = 240;

    typedef logic [15:0] fb_addr_t;
    typedef logic [7:0]  pix_t;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_FWR,
        GNT_RD,
        GNT_CLR,
        GNT_WR
    } gnt_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RUN,
        C_DONE
    } clr_state_e;

    typedef struct packed {
        fb_addr_t addr;
        pix_t     pix;
    } fifo_ent_t;

endpackage

// File: rtl/ppu_fb_arbiter_if.sv
// Requester and RAM-side signals of the framebuffer arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface ppu_fb_arbiter_if;
    import ppu_fb_pkg::*;

    logic       ppu_valid;
    logic [9:0] ppu_x;
    logic [9:0] ppu_y;
    pix_t       ppu_pixel;
    logic       ppu_ready;

    logic       rd_req;
    fb_addr_t   rd_addr;
    logic       rd_gnt;
    pix_t       rd_data;
    logic       rd_data_valid;

    logic       clr_start;
    pix_t       clr_color;
    logic       clr_busy;
    logic       clr_done;

    logic       ram_en;
    logic       ram_we;
    fb_addr_t   ram_addr;
    pix_t       ram_wdata;
    pix_t       ram_rdata;

    modport slave (
        input  ppu_valid, ppu_x, ppu_y, ppu_pixel,
        output ppu_ready,
        input  rd_req, rd_addr,
        output rd_gnt, rd_data, rd_data_valid,
        input  clr_start, clr_color,
        output clr_busy, clr_done,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output ppu_valid, ppu_x, ppu_y, ppu_pixel,
        input  ppu_ready,
        output rd_req, rd_addr,
        input  rd_gnt, rd_data, rd_data_valid,
        output clr_start, clr_color,
        input  clr_busy, clr_done,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ppu_fb_arbiter_wr_fifo.sv
// First-word-fall-through FIFO holding pending PPU pixel writes.
// Push and pop in the same cycle are accepted even when full.
module ppu_fb_wr_fifo
    import ppu_fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      Clk,
    input  logic      reset_n,
    input  logic      push,
    input  fifo_ent_t push_ent,
    input  logic      pop,
    output fifo_ent_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_ent_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_ent;
    end

endmodule

// File: rtl/ppu_fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads, buffered PPU writes and a fill engine
// share one single-port RAM. Optional statistics counters: FB_ARB_STATS_EN.
// ram_rdata is expected RAM_LAT-1 cycles after ram_* is presented; rd_data registers it.
//
// Clear FSM
//   state  | meaning
//   C_IDLE | waiting for clr_start
//   C_RUN  | requesting one write per granted cycle, walking {y,x}
//   C_DONE | last pixel written; clr_done high for this one cycle
module ppu_fb_arbiter
    import ppu_fb_pkg::*;
#(
    parameter int FB_W       = FB_W_C,
    parameter int FB_H       = FB_H_C,
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic               Clk,
    input  logic               reset_n,
    ppu_fb_arbiter_if.slave    bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]        stat_drop_cnt,
    output logic [15:0]        stat_force_cnt
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    gnt_e              gnt;
    clr_state_e        clr_state;
    fb_addr_t          clr_addr;
    pix_t              clr_color_q;
    logic [SW-1:0]     starve_cnt;
    logic [RAM_LAT-1:0] rd_sr;
    logic              on_screen;
    logic              accept;
    logic              push;
    logic              pop;
    fifo_ent_t         push_ent;
    fifo_ent_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              clr_last;
    fb_addr_t          clr_next;

    assign on_screen = (bus.ppu_x < 10'(FB_W)) && (bus.ppu_y < 10'(FB_H));
    assign accept    = bus.ppu_valid && bus.ppu_ready;
    assign push      = accept && on_screen;
    assign push_ent  = '{addr: {bus.ppu_y[7:0], bus.ppu_x[7:0]}, pix: bus.ppu_pixel};
    assign bus.ppu_ready = !fifo_full;

    ppu_fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_ent (push_ent),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Fixed-priority grant: forced write > read > clear > FIFO write.
    always_comb begin
        gnt = GNT_NONE;
        if (fifo_full && (starve_cnt == SW'(STARVE_MAX))) gnt = GNT_FWR;
        else if (bus.rd_req)                              gnt = GNT_RD;
        else if (clr_state == C_RUN)                      gnt = GNT_CLR;
        else if (!fifo_empty)                             gnt = GNT_WR;
    end

    assign pop        = (gnt == GNT_FWR) || (gnt == GNT_WR);
    assign bus.rd_gnt = reset_n && (gnt == GNT_RD);

    assign clr_last = (clr_addr[7:0] == 8'(FB_W - 1)) && (clr_addr[15:8] == 8'(FB_H - 1));
    assign clr_next = (clr_addr[7:0] == 8'(FB_W - 1)) ? {clr_addr[15:8] + 8'd1, 8'd0}
                                                      : {clr_addr[15:8], clr_addr[7:0] + 8'd1};

    // Register the winning request onto the RAM port; idle cycles hold address and data.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            unique case (gnt)
                GNT_FWR, GNT_WR: begin
                    bus.ram_en    <= 1'b1;
                    bus.ram_we    <= 1'b1;
                    bus.ram_addr  <= head.addr;
                    bus.ram_wdata <= head.pix;
                end
                GNT_RD: begin
                    bus.ram_en    <= 1'b1;
                    bus.ram_we    <= 1'b0;
                    bus.ram_addr  <= bus.rd_addr;
                end
                GNT_CLR: begin
                    bus.ram_en    <= 1'b1;
                    bus.ram_we    <= 1'b1;
                    bus.ram_addr  <= clr_addr;
                    bus.ram_wdata <= clr_color_q;
                end
                default: begin
                    bus.ram_en    <= 1'b0;
                    bus.ram_we    <= 1'b0;
                end
            endcase
        end
    end

    // Count reads that win while a full FIFO waits; any pop or free slot restarts it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (pop || !fifo_full) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_RD) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Fill engine: one write per granted cycle over the visible area.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_state   <= C_IDLE;
            clr_addr    <= '0;
            clr_color_q <= '0;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b0;
        end else begin
            unique case (clr_state)
                C_IDLE: begin
                    bus.clr_done <= 1'b0;
                    if (bus.clr_start) begin
                        clr_color_q  <= bus.clr_color;
                        clr_addr     <= '0;
                        bus.clr_busy <= 1'b1;
                        clr_state    <= C_RUN;
                    end
                end
                C_RUN: begin
                    if (gnt == GNT_CLR) begin
                        if (clr_last) begin
                            clr_state    <= C_DONE;
                            bus.clr_busy <= 1'b0;
                            bus.clr_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_next;
                        end
                    end
                end
                C_DONE: begin
                    bus.clr_done <= 1'b0;
                    clr_state    <= C_IDLE;
                end
                default: begin
                    bus.clr_busy <= 1'b0;
                    bus.clr_done <= 1'b0;
                    clr_state    <= C_IDLE;
                end
            endcase
        end
    end

    // Track in-flight reads and capture the returned data.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sr             <= '0;
            bus.rd_data_valid <= 1'b0;
            bus.rd_data       <= '0;
        end else begin
            rd_sr             <= (rd_sr << 1) | RAM_LAT'(gnt == GNT_RD);
            bus.rd_data_valid <= rd_sr[RAM_LAT-1];
            if (rd_sr[RAM_LAT-1]) bus.rd_data <= bus.ram_rdata;
        end
    end

`ifdef FB_ARB_STATS_EN
    // Saturating counts of discarded off-screen pixels and forced write slots.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_drop_cnt  <= '0;
            stat_force_cnt <= '0;
        end else begin
            if (accept && !on_screen && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if ((gnt == GNT_FWR) && (stat_force_cnt != 16'hFFFF))
                stat_force_cnt <= stat_force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ppu_fb_arbiter.sv
// Self-checking bench for ppu_fb_arbiter (RAM_LAT=1, combinational-read RAM stub).
module tb_ppu_fb_arbiter;
    import ppu_fb_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          due;
    } exp_t;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t rd_q[$];
    exp_t wr_q[$];

    ppu_fb_arbiter_if bus();

`ifdef FB_ARB_STATS_EN
    logic [15:0] stat_drop_cnt;
    logic [15:0] stat_force_cnt;
`endif

    ppu_fb_arbiter dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FB_ARB_STATS_EN
        ,
        .stat_drop_cnt  (stat_drop_cnt),
        .stat_force_cnt (stat_force_cnt)
`endif
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    assign bus.ram_rdata = pat(bus.ram_addr);

    task automatic test_reset();
        bus.ppu_valid = 0; bus.ppu_x = 0; bus.ppu_y = 0; bus.ppu_pixel = 0;
        bus.rd_req = 0; bus.rd_addr = 0; bus.clr_start = 0; bus.clr_color = 0;
        reset_n = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.clr_busy !== 1'b0 || bus.rd_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: en=%b we=%b busy=%b vld=%b required all 0", bus.ram_en, bus.ram_we, bus.clr_busy, bus.rd_data_valid);
        end
        @(posedge Clk); #1 reset_n = 1;
        @(negedge Clk);
        n_checks++;
        if (bus.ppu_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", bus.ppu_ready);
        end
        n_checks++;
        if (bus.ram_en !== 1'b0 || bus.rd_gnt !== 1'b0 || bus.clr_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: en=%b gnt=%b busy=%b required 0", bus.ram_en, bus.rd_gnt, bus.clr_busy);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        int seen = 0;
        @(posedge Clk); #1;
        bus.ppu_valid = 1; bus.ppu_x = 10'd3; bus.ppu_y = 10'd2; bus.ppu_pixel = 8'h2A;
        @(negedge Clk);
        n_checks++;
        if (bus.ppu_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready: got %b required 1", bus.ppu_ready);
        end
        e.addr = 16'h0203; e.data = 8'h2A; e.due = cyc + 2;
        wr_q.push_back(e);
        @(posedge Clk); #1 bus.ppu_valid = 0;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            @(negedge Clk);
            if (bus.ram_en && bus.ram_we) begin
                seen = 1;
                e = wr_q.pop_front();
                n_checks++;
                if (bus.ram_addr !== e.addr || bus.ram_wdata !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL wr_single: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             bus.ram_addr, bus.ram_wdata, cyc, e.addr, e.data, e.due);
                end
            end
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++; $display("FAIL wr_single_timeout: got no write required 1 write");
        end
    endtask

    task automatic test_read_stream();
        exp_t e;
        int issued = 0;
        int got = 0;
        int budget = 0;
        rd_q.delete();
        while ((issued < 256 || got < 256) && budget < 400) begin
            @(posedge Clk); #1;
            bus.rd_req  = (issued < 256);
            bus.rd_addr = 16'(issued);
            @(negedge Clk);
            if (issued < 256) begin
                n_checks++;
                if (bus.rd_gnt !== 1'b1) begin
                    n_fail++; $display("FAIL rd_gnt: addr=%h got %b required 1", bus.rd_addr, bus.rd_gnt);
                end else begin
                    e.addr = bus.rd_addr; e.data = pat(16'(issued)); e.due = cyc + 2;
                    rd_q.push_back(e);
                    issued++;
                end
            end
            if (bus.rd_data_valid === 1'b1) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_extra: got data=%h required no pulse", bus.rd_data);
                end else begin
                    e = rd_q.pop_front();
                    if (bus.rd_data !== e.data || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL rd_data: addr=%h got %h@%0d required %h@%0d", e.addr, bus.rd_data, cyc, e.data, e.due);
                    end
                end
                got++;
            end
            budget++;
        end
        bus.rd_req = 0;
        n_checks++;
        if (got != 256) begin
            n_fail++; $display("FAIL rd_count: got %0d pulses required 256", got);
        end
    endtask

    task automatic test_starve();
        exp_t e;
        int blocked = 0;
        int forced = 0;
        int drained = 0;
        wr_q.delete();
        bus.rd_req = 1; bus.rd_addr = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            bus.ppu_valid = 1; bus.ppu_x = 10'(i); bus.ppu_y = 10'h10; bus.ppu_pixel = 8'h80 + 8'(i);
            @(negedge Clk);
            n_checks++;
            if (bus.ppu_ready !== 1'b1) begin
                n_fail++; $display("FAIL starve_fill_ready: entry %0d got %b required 1", i, bus.ppu_ready);
            end else begin
                e.addr = 16'h1000 + 16'(i); e.data = 8'h80 + 8'(i); e.due = 0;
                wr_q.push_back(e);
            end
        end
        @(posedge Clk); #1 bus.ppu_valid = 0;
        for (int i = 0; i < 20 && forced == 0; i++) begin
            @(negedge Clk);
            if (bus.rd_gnt !== 1'b1) forced = 1;
            else if (bus.ppu_ready === 1'b0) blocked++;
        end
        n_checks++;
        if (forced != 1 || blocked != 8) begin
            n_fail++; $display("FAIL starve_blocked: got %0d blocked cycles (forced=%0d) required 8", blocked, forced);
        end
        @(negedge Clk);
        n_checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h1000 || bus.ram_wdata !== 8'h80) begin
            n_fail++;
            $display("FAIL starve_forced_wr: got en=%b we=%b addr=%h data=%h required 1 1 1000 80",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        if (wr_q.size() != 0) void'(wr_q.pop_front());
        n_checks++;
        if (bus.ppu_ready !== 1'b1) begin
            n_fail++; $display("FAIL starve_ready_after: got %b required 1", bus.ppu_ready);
        end
`ifdef FB_ARB_STATS_EN
        n_checks++;
        if (stat_force_cnt !== 16'd1) begin
            n_fail++; $display("FAIL stat_force: got %0d required 1", stat_force_cnt);
        end
`endif
        @(posedge Clk); #1 bus.rd_req = 0;
        for (int i = 0; i < 10 && drained < 3; i++) begin
            @(negedge Clk);
            if (bus.ram_en && bus.ram_we && wr_q.size() != 0) begin
                e = wr_q.pop_front();
                n_checks++;
                if (bus.ram_addr !== e.addr || bus.ram_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL starve_drain: got addr=%h data=%h required addr=%h data=%h", bus.ram_addr, bus.ram_wdata, e.addr, e.data);
                end
                drained++;
            end
        end
        n_checks++;
        if (drained != 3) begin
            n_fail++; $display("FAIL starve_drain_count: got %0d required 3", drained);
        end
    endtask

    task automatic test_offscreen();
        int writes = 0;
        logic [9:0] xs [2];
        logic [9:0] ys [2];
        xs[0] = 10'd300; ys[0] = 10'd10;
        xs[1] = 10'd5;   ys[1] = 10'd240;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            bus.ppu_valid = 1; bus.ppu_x = xs[k]; bus.ppu_y = ys[k]; bus.ppu_pixel = 8'h77;
            @(negedge Clk);
            n_checks++;
            if (bus.ppu_ready !== 1'b1) begin
                n_fail++; $display("FAIL offscreen_ready: case %0d got %b required 1", k, bus.ppu_ready);
            end
            @(posedge Clk); #1 bus.ppu_valid = 0;
            writes = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge Clk);
                if (bus.ram_en === 1'b1) writes++;
            end
            n_checks++;
            if (writes != 0 || bus.ppu_ready !== 1'b1) begin
                n_fail++; $display("FAIL offscreen_write: case %0d got %0d RAM cycles ready=%b required 0 and 1", k, writes, bus.ppu_ready);
            end
`ifdef FB_ARB_STATS_EN
            n_checks++;
            if (stat_drop_cnt !== 16'(k + 1)) begin
                n_fail++; $display("FAIL stat_drop: got %0d required %0d", stat_drop_cnt, k + 1);
            end
`endif
        end
    endtask

    task automatic test_clear();
        exp_t e;
        int nwr = 0;
        int bad = 0;
        int done = 0;
        int extra_done = 0;
        int seen_fifo = 0;
        logic [15:0] exp_addr = 16'h0000;
        logic [15:0] done_addr = 16'h0000;
        logic done_busy = 1'b1;
        wr_q.delete();
        @(posedge Clk); #1 bus.clr_start = 1; bus.clr_color = 8'h0F;
        @(posedge Clk); #1 bus.clr_start = 0; bus.clr_color = 8'h33;
        @(negedge Clk);
        n_checks++;
        if (bus.clr_busy !== 1'b1) begin
            n_fail++; $display("FAIL clr_busy_rise: got %b required 1", bus.clr_busy);
        end
        for (int k = 0; k < 70000 && done == 0; k++) begin
            @(posedge Clk); #1;
            bus.ppu_valid = (k == 20);
            bus.clr_start = (k == 30);
            bus.ppu_x = 10'd7; bus.ppu_y = 10'd0; bus.ppu_pixel = 8'h55;
            @(negedge Clk);
            if (k == 20 && bus.ppu_ready === 1'b1) begin
                e.addr = 16'h0007; e.data = 8'h55; e.due = 0;
                wr_q.push_back(e);
            end
            if (bus.ram_en && bus.ram_we) begin
                if (bus.ram_addr !== exp_addr || bus.ram_wdata !== 8'h0F) begin
                    if (bad == 0) $display("FAIL clr_write: got addr=%h data=%h required addr=%h data=0f", bus.ram_addr, bus.ram_wdata, exp_addr);
                    bad++;
                end
                exp_addr = exp_addr + 16'd1;
                nwr++;
            end
            if (bus.clr_done === 1'b1) begin
                done = 1;
                done_busy = bus.clr_busy;
                done_addr = bus.ram_addr;
            end
        end
        bus.ppu_valid = 0; bus.clr_start = 0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL clr_sequence: got %0d bad writes required 0", bad);
        end
        n_checks++;
        if (nwr != 61440) begin
            n_fail++; $display("FAIL clr_count: got %0d writes required 61440", nwr);
        end
        n_checks++;
        if (done != 1 || done_busy !== 1'b0 || done_addr !== 16'hEFFF) begin
            n_fail++; $display("FAIL clr_done: got done=%0d busy=%b last=%h required 1 0 efff", done, done_busy, done_addr);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.clr_done === 1'b1 || bus.clr_busy === 1'b1) extra_done++;
            if (bus.ram_en && bus.ram_we) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++; $display("FAIL clr_post_write: got addr=%h required none", bus.ram_addr);
                end else begin
                    e = wr_q.pop_front();
                    seen_fifo++;
                    if (bus.ram_addr !== e.addr || bus.ram_wdata !== e.data) begin
                        n_fail++; $display("FAIL clr_post_write: got addr=%h data=%h required addr=%h data=%h", bus.ram_addr, bus.ram_wdata, e.addr, e.data);
                    end
                end
            end
        end
        n_checks++;
        if (extra_done != 0 || seen_fifo != 1) begin
            n_fail++; $display("FAIL clr_after: got %0d busy/done cycles, %0d PPU writes required 0 and 1", extra_done, seen_fifo);
        end
    endtask

    task automatic test_reset_mid_clear();
        int hit = 0;
        int activity = 0;
        @(posedge Clk); #1 bus.clr_start = 1; bus.clr_color = 8'hA5;
        @(posedge Clk); #1 bus.clr_start = 0;
        for (int k = 0; k < 6000 && hit == 0; k++) begin
            @(negedge Clk);
            if (bus.ram_en && bus.ram_we && bus.ram_addr == 16'h1234) hit = 1;
            else begin
                @(posedge Clk); #1;
            end
        end
        n_checks++;
        if (hit == 0) begin
            n_fail++; $display("FAIL rst_mid_reach: got no write to 1234 required one");
        end
        bus.rd_req = 1; bus.rd_addr = 16'h0001;
        reset_n = 0;
        #1;
        n_checks++;
        if (bus.ram_en !== 0 || bus.ram_we !== 0 || bus.ram_addr !== 0 || bus.ram_wdata !== 0 ||
            bus.rd_data !== 0 || bus.rd_data_valid !== 0 || bus.clr_busy !== 0 || bus.clr_done !== 0 || bus.rd_gnt !== 0) begin
            n_fail++;
            $display("FAIL rst_async: got en=%b we=%b addr=%h wd=%h rd=%h vld=%b busy=%b done=%b gnt=%b required all 0",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rd_data, bus.rd_data_valid,
                     bus.clr_busy, bus.clr_done, bus.rd_gnt);
        end
        repeat (2) @(posedge Clk);
        #1 bus.rd_req = 0; reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus.clr_busy === 1'b1 || bus.clr_done === 1'b1 || bus.ram_en === 1'b1) activity++;
        end
        n_checks++;
        if (activity != 0 || bus.ppu_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_after: got %0d active cycles ready=%b required 0 and 1", activity, bus.ppu_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_stream();
        test_starve();
        test_offscreen();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
